// File: rtl/mem_pkg.sv
// Shared types and pure helpers for the MEM-stage data-memory responder:
// funct3 codes, FSM states, the latched request, and sizing/extension functions.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, BUSY, ACK} dmc_state_t;

    typedef struct packed {
        logic        op_write;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    function automatic logic f3_valid(input logic op_write, input logic [2:0] f3);
        if (op_write) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_H, F3_HU: return a[0];
            F3_W:        return a != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_B:    return 4'b0001 << a;
            F3_H:    return a[1] ? 4'b1100 : 4'b0011;
            F3_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate the store operand onto every lane it may land in; byte enables pick the lane.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_B:    return {4{d[7:0]}};
            F3_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'h0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'h0, h};
            F3_W:    return word;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/data_ram.sv
// Word-organised data RAM: synchronous byte-enabled write, combinational read.
// Contents are deliberately not reset.
module data_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_mem_ctrl.sv
// Fixed-latency data-memory responder for the MEM stage: stalls the pipeline via
// busywait, performs sized loads/stores, flags misaligned accesses.
//   state | meaning
//   IDLE  | waiting; a request is latched and busywait asserts combinationally
//   BUSY  | counting down latency; access happens on the edge leaving BUSY
//   ACK   | single cycle with busywait low so the pipeline advances
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] D_in,
    output logic [31:0] D_out,
    output logic        busywait,
    output logic        misaligned
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    if (LATENCY < 1) begin : g_bad_latency
        $error("data_mem_ctrl: LATENCY must be at least 1");
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("data_mem_ctrl: DEPTH_WORDS must be a power of two, at least 2");
    end

    dmc_state_t    r_state, w_state_nxt;
    logic [CW-1:0] r_count;
    req_t          r_req;
    logic [31:0]   r_dout;
    logic          r_mis;

    logic          w_busy, w_done, w_valid, w_mis, w_we;
    logic [31:0]   w_rdata;
    logic          w_unused_addr;

    assign w_done  = (r_state == BUSY) && (r_count == '0);
    assign w_valid = f3_valid(r_req.op_write, r_req.funct3);
    assign w_mis   = w_valid && is_misaligned(r_req.funct3, r_req.addr[1:0]);
    assign w_we    = w_done && r_req.op_write && w_valid && !w_mis;
    assign w_unused_addr = ^r_req.addr[31:AW+2];

    data_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_be    (byte_en(r_req.funct3, r_req.addr[1:0])),
        .i_idx   (r_req.addr[AW+1:2]),
        .i_wdata (store_lanes(r_req.funct3, r_req.wdata)),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_req   <= '0;
            r_dout  <= '0;
            r_mis   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mis   <= w_done && w_mis;
            case (r_state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        r_req   <= '{op_write: mem_write, funct3: funct3, addr: addr, wdata: D_in};
                        r_count <= CW'(LATENCY - 1);
                    end
                end
                BUSY: begin
                    if (r_count != '0) begin
                        r_count <= r_count - CW'(1);
                    end else if (!r_req.op_write) begin
                        r_dout <= (w_valid && !w_mis)
                                  ? load_ext(r_req.funct3, r_req.addr[1:0], w_rdata) : 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = mem_read || mem_write;
                if (mem_read || mem_write) w_state_nxt = BUSY;
            end
            BUSY: begin
                w_busy = 1'b1;
                if (r_count == '0) w_state_nxt = ACK;
            end
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Held low during reset even if the MEM stage keeps its request up.
    assign busywait   = w_busy && reset;
    assign D_out      = r_dout;
    assign misaligned = r_mis;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a byte-array reference model predicts each
// access, a negedge monitor checks stall length, D_out and misaligned at every ACK.
module tb_data_mem_ctrl;
    import mem_pkg::*;

    localparam int DEPTH  = 256;
    localparam int LAT    = 3;
    localparam int NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] D_in = 32'h0;
    logic [31:0] D_out;
    logic        busywait;
    logic        misaligned;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .D_in       (D_in),
        .D_out      (D_out),
        .busywait   (busywait),
        .misaligned (misaligned)
    );

    typedef struct {
        logic [31:0] dout;
        logic        mis;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          stall = 0;
    logic [7:0]  m_mem [NBYTES];
    logic [31:0] m_dout = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: plain byte memory, access size from funct3, RV32I rules.
    function automatic exp_t model(input logic is_wr, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] d);
        int          size;
        bit          known;
        bit          mis;
        int unsigned base;
        logic [31:0] v;
        exp_t        e;
        case (f3[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 0;
        endcase
        if (is_wr) known = (f3 <= 3'd2);
        else       known = (f3 != 3'd3) && (f3 < 3'd6);
        mis = 1'b0;
        if (known) mis = (a % size) != 0;
        base = a % NBYTES;
        if (is_wr) begin
            if (known && !mis)
                for (int k = 0; k < size; k++) m_mem[(base + k) % NBYTES] = d[8*k +: 8];
        end else if (!known || mis) begin
            m_dout = 32'h0;
        end else begin
            v = 32'h0;
            for (int k = 0; k < size; k++) v[8*k +: 8] = m_mem[base + k];
            if (size == 4 || f3[2])  m_dout = v;
            else if (size == 1)      m_dout = 32'($signed(v[7:0]));
            else                     m_dout = 32'($signed(v[15:0]));
        end
        e.dout = m_dout;
        e.mis  = mis;
        return e;
    endfunction

    // Called just after a posedge; returns during the ACK cycle with inputs still held.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        int n;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        D_in      = d;
        sb_q.push_back(model(wr, f3, a, d));
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (busywait !== 1'b0 && n < 20);
        if (n >= 20) begin
            n_err++;
            $display("FAIL issue_timeout: busywait still %b after %0d cycles, expected low by %0d",
                     busywait, n, LAT + 2);
        end
    endtask

    task automatic idle(input int cycles);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            stall = 0;
        end else if (busywait) begin
            stall++;
            check("mis_outside_ack", {31'h0, misaligned}, 32'h0);
        end else if (stall > 0) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ack: got an ACK, expected no pending access");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("stall_len", 32'(stall), 32'(LAT + 1));
                check("d_out", D_out, e.dout);
                check("misaligned", {31'h0, misaligned}, {31'h0, e.mis});
            end
            stall = 0;
        end
    end

    initial begin
        int kind;
        #2;
        check("rst_dout", D_out, 32'h0);
        check("rst_busy", {31'h0, busywait}, 32'h0);
        check("rst_mis", {31'h0, misaligned}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        for (int w = 0; w < DEPTH; w++) issue(1'b0, 1'b1, F3_W, 32'(w * 4), $urandom);
        idle(1);

        issue(1'b0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF); idle(1);
        issue(1'b1, 1'b0, F3_W, 32'h10, 32'h0);        idle(1);
        issue(1'b1, 1'b0, F3_B, 32'h13, 32'h0);
        issue(1'b1, 1'b0, F3_BU, 32'h13, 32'h0);
        issue(1'b1, 1'b0, F3_H, 32'h12, 32'h0);
        issue(1'b1, 1'b0, F3_HU, 32'h10, 32'h0);       idle(1);
        issue(1'b0, 1'b1, F3_B, 32'h11, 32'h12345678);
        issue(1'b1, 1'b0, F3_W, 32'h10, 32'h0);
        issue(1'b0, 1'b1, F3_H, 32'h12, 32'hAAAA5555);
        issue(1'b1, 1'b0, F3_W, 32'h10, 32'h0);        idle(2);
        issue(1'b1, 1'b0, F3_W, 32'h12, 32'h0);
        issue(1'b0, 1'b1, F3_W, 32'h11, 32'h01020304);
        issue(1'b1, 1'b0, F3_W, 32'h10, 32'h0);
        issue(1'b0, 1'b1, F3_W, 32'h400, 32'hCAFEF00D);
        issue(1'b1, 1'b0, F3_W, 32'h000, 32'h0);
        issue(1'b1, 1'b1, F3_W, 32'h20, 32'h55AA55AA);
        issue(1'b1, 1'b0, 3'b111, 32'h20, 32'h0);
        issue(1'b0, 1'b1, 3'b101, 32'h20, 32'hFFFFFFFF);
        issue(1'b1, 1'b0, F3_W, 32'h20, 32'h0);        idle(1);

        // Abandon a store mid-BUSY with reset, then restart as a load.
        mem_write = 1'b1; mem_read = 1'b0; funct3 = F3_W; addr = 32'h20; D_in = 32'h1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("midrst_busy", {31'h0, busywait}, 32'h0);
        check("midrst_dout", D_out, 32'h0);
        check("midrst_mis", {31'h0, misaligned}, 32'h0);
        m_dout = 32'h0;
        @(posedge clk); #1;
        mem_write = 1'b0; mem_read = 1'b1;
        reset = 1'b1;
        issue(1'b1, 1'b0, F3_W, 32'h20, 32'h0);
        idle(1);

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 2);
            issue(kind != 1, kind != 0, 3'($urandom_range(0, 7)), $urandom, $urandom);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(4);
        check("sb_drain", 32'(sb_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Responder side of the MEM-stage data-memory interface: accepts load/store requests, drives `busywait` to stall the pipeline, and returns load data on `D_out`.
- Sits between the MEM stage and the MEM/WB pipeline register.
- Models a fixed-latency, byte-addressable data RAM.
- Handles RV32I LB/LH/LW/LBU/LHU/SB/SH/SW sizing, sign extension and misalignment detection.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the RAM; must be a power of two, at least 2.
- LATENCY, 3, number of BUSY-state cycles per access; must be at least 1; elaboration error otherwise.

Ports:
- clk  in  1  clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_read  in  1  load request; held stable by MEM stage while busywait=1.
- mem_write  in  1  store request; held stable by MEM stage while busywait=1.
- funct3  in  3  access size/sign, RV32I load/store encoding.
- addr  in  32  byte address (ALU result).
- D_in  in  32  store data (rs2); low byte/half used for SB/SH.
- D_out  out  32  load data, extended per funct3; registered.
- busywait  out  1  stall request to the pipeline.
- misaligned  out  1  one-cycle pulse at completion of a misaligned access.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, D_out=0, misaligned=0.
  - RAM contents are not reset.
- States: IDLE, BUSY, ACK.
- busywait = (state==IDLE && (mem_read||mem_write)) || state==BUSY. It is combinational in IDLE and low in ACK.
- IDLE:
  - If mem_read or mem_write is high: latch addr, funct3, D_in and op into request registers; counter<=LATENCY-1; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If counter!=0: counter decrements.
  - If counter==0: perform the access at this clock edge and go to ACK.
- ACK:
  - Exactly one cycle. busywait=0, so the pipeline advances at the end of this cycle.
  - Always return to IDLE; the held request is never retriggered.
- Stall length: busywait is high for LATENCY+1 consecutive cycles per access, then low for one ACK cycle.
- Word index: addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses alias modulo DEPTH_WORDS*4.
- Load data at the BUSY→ACK edge:
  - LB/LBU select the byte at addr[1:0]; LH/LHU select the half at addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Result is registered into D_out.
- D_out holds its value until the next load completes.
- Stores write at the BUSY→ACK edge with byte enables:
  - SB: one byte lane at addr[1:0], written from D_in[7:0].
  - SH: lanes {addr[1],0} and {addr[1],1}, written from D_in[15:0].
  - SW: all four lanes.
- Stores leave D_out unchanged.
- Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0):
  - Full latency still elapses.
  - No RAM write.
  - A misaligned load sets D_out=0.
  - misaligned=1 during the ACK cycle only.
- Undefined funct3 (load 011/110/111, store 011–111):
  - Full latency elapses; no RAM write; load returns D_out=0; misaligned stays 0.
- mem_read and mem_write both high: treated as a store; D_out unchanged.
- Request deasserted while in BUSY: the latched request still completes. Request registers, not live inputs, drive the access.
- Reset mid-access: the access is abandoned with no RAM write. After release, a still-present request starts a fresh access from IDLE.
- Back-to-back requests: the request seen in IDLE directly after ACK is treated as a new access. Minimum period is LATENCY+2 cycles.

Decomposition:
- mem_pkg:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum dmc_state_t {IDLE, BUSY, ACK}.
  - Packed struct req_t {op_write, funct3, addr, wdata}.
  - Pure functions: misaligned check, byte-enable generation, load extraction/extension.
- Sub-module data_ram:
  - Word array of DEPTH_WORDS words.
  - Synchronous write with 4-bit byte enable; combinational read.
  - Controller owns FSM, counter and D_out register.

Test Plan:
- After reset, LATENCY=3: SW D_in=0xDEADBEEF at addr 0x10 → busywait high for 4 cycles, ACK low 1 cycle. Then LW 0x10 → D_out=0xDEADBEEF after 4 stall cycles.
- With word 0x10 = 0xDEADBEEF:
  - LB 0x13 → 0xFFFFFFDE.
  - LBU 0x13 → 0x000000DE.
  - LH 0x12 → 0xFFFFDEAD.
  - LHU 0x10 → 0x0000BEEF.
- SB D_in=0x12345678 at 0x11, then LW 0x10 → 0xDEAD78EF. SH D_in=0xAAAA5555 at 0x12, then LW → 0x555578EF.
- LW addr 0x12 → full stall, misaligned pulses 1 cycle in ACK, D_out=0. SW 0x11 → misaligned pulses and a subsequent LW 0x10 is unchanged.
- DEPTH_WORDS=256: SW 0xCAFEF00D at 0x400, then LW 0x000 → 0xCAFEF00D (aliasing).
- Assert reset mid-BUSY of SW 0x20 data 0x1 → D_out=0, busywait=0 while in reset, no write; after release with mem_read=1 at 0x20 → fresh 4-cycle stall, D_out equals prior contents.
